rf_op_sequencer: RTL and testbench
==================================

# rf_op_sequencer

Initiator-side controller for the 16-entry general-purpose register file. It accepts one decoded register-register operation through a valid/ready handshake. It then reads both source operands over the file's read ports, executes the operation in a small ALU, and writes the result back over the file's write port. The block sits between instruction decode and the register file and owns every address, write-data and load strobe the file sees.

## Interface
Parameters:
- DATA_W, 16, register and result width
- ADDR_W, 4, register address width (16 registers)

Ports:
- clk  in  1  sole clock, rising edge
- clear_n  in  1  asynchronous, active-low reset
- op_valid  in  1  decoded op present
- op_ready  out  1  sequencer can accept an op
- op_code  in  3  operation select
- op_rs  in  ADDR_W  source A register
- op_rt  in  ADDR_W  source B register
- op_rd  in  ADDR_W  destination register
- rf_aaddr  out  ADDR_W  register-file read address A
- rf_baddr  out  ADDR_W  register-file read address B
- rf_a  in  DATA_W  read data A (combinational from file)
- rf_b  in  DATA_W  read data B (combinational from file)
- rf_caddr  out  ADDR_W  write address
- rf_c  out  DATA_W  write data
- rf_load  out  1  write strobe, one cycle
- result  out  DATA_W  last computed result
- ovf  out  1  signed overflow of last ADD/SUB
- done  out  1  one-cycle completion pulse
- busy  out  1  state != IDLE

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
- 101 SLT: signed compare; result {15'b0, A<B}.
- 110 SLL: result A << B[3:0].
- 111 NOP: no writeback.
- Arithmetic wraps modulo 2^16. ovf = signed overflow for ADD/SUB; 0 for all other ops.
- FSM states: IDLE, READ, EXEC, WB.
- IDLE: op_ready=1. On op_valid&&op_ready, latch op_code/rs/rt/rd; go to READ.
- READ: rf_aaddr=rs_q, rf_baddr=rt_q. At the edge, capture rf_a/rf_b into opa/opb; go to EXEC.
- EXEC: ALU evaluates opa/opb. At the edge, register result and ovf; go to WB.
- WB: rf_caddr=rd_q, rf_c=result. rf_load=1 unless op is NOP or rd_q==0; writes to register 0 are always suppressed. done=1. Go to IDLE.
- rf_aaddr/rf_baddr/rf_caddr always reflect the latched rs/rt/rd. rf_c always equals result. Only rf_load qualifies a write.
- op_ready is high only in IDLE. There is no skid buffer, and op inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE, op_ready=1, busy=0, rf_load=0, done=0, ovf=0, result=0. All addresses and rf_c are 0.
- Acceptance edge E0; READ cycle E0–E1; EXEC E1–E2; WB E2–E3. The register file commits at E3.
- done and rf_load are high for exactly the WB cycle, i.e. the third cycle after acceptance.
- Earliest next acceptance is E4, so throughput is one op per 4 cycles.
- A dependent back-to-back op reads the already-committed value, so no forwarding is needed.
- result/ovf hold their value until the next EXEC edge.
- clear_n low at any time forces IDLE immediately and drops rf_load and done combinationally-fast (async). An in-flight op is discarded with no write.
- op_valid held high while busy: the op is accepted on the first IDLE cycle. The decoder must hold stable fields until accepted.

## Structure
- Shared package rf_seq_pkg:
  - DATA_W/ADDR_W constants
  - op_code enum (ADD..NOP)
  - FSM state enum
  - REG_ZERO address constant
- Sub-module alu16: purely combinational. Inputs op, a, b; outputs y, ovf.
- Top level holds the FSM, the op/operand latches, and the output registers.

## Test plan
- Register file preloaded R1=2, R2=5. ADD rs=1 rt=2 rd=3:
  - rf_aaddr=1, rf_baddr=2 in READ.
  - rf_caddr=3, rf_c=0x0007, rf_load=1 and done=1 exactly 3 cycles after acceptance.
  - R3 reads 7 afterwards.
- SUB rs=1 rt=2 rd=4 → rf_c=0xFFFD, ovf=0. ADD with operands 0x7FFF and 0x0001 → rf_c=0x8000, ovf=1.
- SLT (2,5) → 1; SLT (0xFFFF,1) → 1; SLL 0x0003<<4 → 0x0030. Each produces one rf_load pulse.
- rd=0 with ADD → done pulses, rf_load stays 0, R0 unchanged. NOP → done pulses, rf_load stays 0.
- Back-to-back: ADD 1+2→3, then ADD 3+3→5, with op_valid held high. The second op is accepted 4 cycles after the first and writes 0x000E to R5. op_ready is 0 in between.
- Assert clear_n low during EXEC:
  - busy=0 and op_ready=1 immediately.
  - No rf_load pulse ever occurs for that op; result=0.
  - The next op completes normally.

Source files
------------

// File: rtl/rf_seq_pkg.sv
// Shared types and constants for the register-file op sequencer.
package rf_seq_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_NOP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Register 0 is hardwired; writes to it are dropped.
  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_op_sequencer_alu16.sv
// Combinational ALU: wrapping arithmetic, logic ops, signed compare and left shift.
module alu16
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  op_e                       op,
  input  logic signed [DATA_W-1:0]  a,
  input  logic signed [DATA_W-1:0]  b,
  output logic signed [DATA_W-1:0]  y,
  output logic                      ovf
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic signed [DATA_W-1:0] w_sum;
  logic signed [DATA_W-1:0] w_diff;
  logic                     w_lt;

  assign w_sum  = a + b;
  assign w_diff = a - b;
  assign w_lt   = (a < b);

  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        y   = w_sum;
        ovf = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        y   = w_diff;
        ovf = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_SLT: y = {{(DATA_W-1){1'b0}}, w_lt};
      OP_SLL: y = a << b[SH_W-1:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// Four-state sequencer: accept op, read operands, execute, write back.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [ADDR_W-1:0] op_rs,
  input  logic [ADDR_W-1:0] op_rt,
  input  logic [ADDR_W-1:0] op_rd,
  output logic [ADDR_W-1:0] rf_aaddr,
  output logic [ADDR_W-1:0] rf_baddr,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  output logic [ADDR_W-1:0] rf_caddr,
  output logic [DATA_W-1:0] rf_c,
  output logic              rf_load,
  output logic [DATA_W-1:0] result,
  output logic              ovf,
  output logic              done,
  output logic              busy
);

  state_e                   r_state;
  op_e                      r_op_p0;
  logic [ADDR_W-1:0]        r_rs_p0;
  logic [ADDR_W-1:0]        r_rt_p0;
  logic [ADDR_W-1:0]        r_rd_p0;
  logic signed [DATA_W-1:0] r_opa_p1;
  logic signed [DATA_W-1:0] r_opb_p1;
  logic signed [DATA_W-1:0] r_result_p2;
  logic                     r_ovf_p2;

  logic signed [DATA_W-1:0] w_y;
  logic                     w_ovf;
  logic [ADDR_W-1:0]        w_zero;

  assign w_zero = ADDR_W'(REG_ZERO);

  alu16 #(.DATA_W(DATA_W)) u_alu (
    .op  (r_op_p0),
    .a   (r_opa_p1),
    .b   (r_opb_p1),
    .y   (w_y),
    .ovf (w_ovf)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state     <= ST_IDLE;
      r_op_p0     <= OP_ADD;
      r_rs_p0     <= '0;
      r_rt_p0     <= '0;
      r_rd_p0     <= '0;
      r_opa_p1    <= '0;
      r_opb_p1    <= '0;
      r_result_p2 <= '0;
      r_ovf_p2    <= 1'b0;
    end else begin
      case (r_state)
        // p0: latch the decoded op
        ST_IDLE: begin
          if (op_valid) begin
            r_op_p0 <= op_e'(op_code);
            r_rs_p0 <= op_rs;
            r_rt_p0 <= op_rt;
            r_rd_p0 <= op_rd;
            r_state <= ST_READ;
          end
        end
        // p1: capture operands from the file's combinational read ports
        ST_READ: begin
          r_opa_p1 <= rf_a;
          r_opb_p1 <= rf_b;
          r_state  <= ST_EXEC;
        end
        // p2: register ALU result
        ST_EXEC: begin
          r_result_p2 <= w_y;
          r_ovf_p2    <= w_ovf;
          r_state     <= ST_WB;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async clear drops them at once.
  assign op_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_WB);
  assign rf_load  = (r_state == ST_WB) && (r_op_p0 != OP_NOP) && (r_rd_p0 != w_zero);

  assign rf_aaddr = r_rs_p0;
  assign rf_baddr = r_rt_p0;
  assign rf_caddr = r_rd_p0;
  assign rf_c     = r_result_p2;
  assign result   = r_result_p2;
  assign ovf      = r_ovf_p2;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Randomised and directed bench for rf_op_sequencer with a behavioural register file and ALU model.
module tb_rf_op_sequencer;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = 3'd0;
  logic [3:0]  op_rs = 4'd0, op_rt = 4'd0, op_rd = 4'd0;
  logic [3:0]  rf_aaddr, rf_baddr, rf_caddr;
  logic [15:0] rf_a, rf_b, rf_c, result;
  logic        rf_load, ovf, done, busy;

  logic [15:0] mem [16];
  logic [15:0] mdl [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = 4'd0;
  logic [15:0] pl_data = 16'd0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_op_sequencer dut (
    .clk(clk), .clear_n(clear_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_rs(op_rs), .op_rt(op_rt), .op_rd(op_rd),
    .rf_aaddr(rf_aaddr), .rf_baddr(rf_baddr), .rf_a(rf_a), .rf_b(rf_b),
    .rf_caddr(rf_caddr), .rf_c(rf_c), .rf_load(rf_load), .result(result),
    .ovf(ovf), .done(done), .busy(busy)
  );

  // Register file: combinational reads, write on rising edge.
  assign rf_a = mem[rf_aaddr];
  assign rf_b = mem[rf_baddr];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (rf_load) mem[rf_caddr] <= rf_c;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] y, output logic v);
    int sa, sb, r;
    logic [31:0] w;
    sa = $signed(a);
    sb = $signed(b);
    v = 1'b0;
    y = 16'd0;
    case (c)
      3'd0: begin r = sa + sb; y = r[15:0]; v = (r > 32767) || (r < -32768); end
      3'd1: begin r = sa - sb; y = r[15:0]; v = (r > 32767) || (r < -32768); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: y = (sa < sb) ? 16'd1 : 16'd0;
      3'd6: begin w = {16'd0, a} << b[3:0]; y = w[15:0]; end
      default: y = 16'd0;
    endcase
  endfunction

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    mdl[a] = d;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!op_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!op_ready) check_eq("ready_timeout", 32'(op_ready), 32'd1);
  endtask

  // One full transaction with cycle-by-cycle checks against the model.
  task automatic run_op(input logic [2:0] c, input logic [3:0] s, input logic [3:0] t,
                        input logic [3:0] d, output logic [15:0] got_c);
    logic [15:0] ey;
    logic        ev, eload;
    wait_ready();
    @(negedge clk);
    op_valid = 1'b1; op_code = c; op_rs = s; op_rt = t; op_rd = d;
    @(posedge clk); #1;
    op_valid = 1'b0;
    ref_alu(c, mdl[s], mdl[t], ey, ev);
    eload = (c != 3'd7) && (d != 4'd0);
    check_eq("read_aaddr", 32'(rf_aaddr), 32'(s));
    check_eq("read_baddr", 32'(rf_baddr), 32'(t));
    check_eq("read_ready", 32'(op_ready), 32'd0);
    check_eq("read_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check_eq("exec_done", 32'(done), 32'd0);
    check_eq("exec_load", 32'(rf_load), 32'd0);
    @(posedge clk); #1;
    got_c = rf_c;
    check_eq("wb_done", 32'(done), 32'd1);
    check_eq("wb_load", 32'(rf_load), 32'(eload));
    check_eq("wb_caddr", 32'(rf_caddr), 32'(d));
    check_eq("wb_ovf", 32'(ovf), 32'(ev));
    if (c != 3'd7) check_eq("wb_rf_c", 32'(rf_c), 32'(ey));
    if (eload) mdl[d] = ey;
    @(posedge clk); #1;
    check_eq("post_done", 32'(done), 32'd0);
    check_eq("post_ready", 32'(op_ready), 32'd1);
    check_eq("post_mem", 32'(mem[d]), 32'(mdl[d]));
  endtask

  initial begin
    logic [15:0] gc;
    logic [2:0]  rc;
    for (int i = 0; i < 16; i++) mdl[i] = 16'd0;
    #12;
    check_eq("rst_ready", 32'(op_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_load", 32'(rf_load), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_addrs", {20'd0, rf_aaddr, rf_baddr, rf_caddr}, 32'd0);
    check_eq("rst_rf_c", 32'(rf_c), 32'd0);
    @(negedge clk);
    clear_n = 1'b1;
    for (int i = 0; i < 16; i++) preload(4'(i), 16'd0);
    preload(4'd1, 16'd2);
    preload(4'd2, 16'd5);
    preload(4'd6, 16'h7FFF);
    preload(4'd7, 16'h0001);
    preload(4'd10, 16'hFFFF);
    preload(4'd12, 16'h0003);
    preload(4'd13, 16'h0004);

    run_op(3'd0, 4'd1, 4'd2, 4'd3, gc);  check_eq("add_c", 32'(gc), 32'h7);
    check_eq("add_r3", 32'(mem[3]), 32'h7);
    run_op(3'd1, 4'd1, 4'd2, 4'd4, gc);  check_eq("sub_c", 32'(gc), 32'hFFFD);
    run_op(3'd0, 4'd6, 4'd7, 4'd8, gc);  check_eq("addovf_c", 32'(gc), 32'h8000);
    check_eq("addovf_flag", 32'(ovf), 32'd1);
    run_op(3'd5, 4'd1, 4'd2, 4'd9, gc);  check_eq("slt_pos", 32'(gc), 32'd1);
    run_op(3'd5, 4'd10, 4'd7, 4'd11, gc); check_eq("slt_neg", 32'(gc), 32'd1);
    run_op(3'd6, 4'd12, 4'd13, 4'd14, gc); check_eq("sll_c", 32'(gc), 32'h30);
    run_op(3'd0, 4'd1, 4'd2, 4'd0, gc);  check_eq("r0_kept", 32'(mem[0]), 32'd0);
    run_op(3'd7, 4'd1, 4'd2, 4'd9, gc);

    // Back-to-back with op_valid held high; second op waits for IDLE.
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd0; op_rs = 4'd1; op_rt = 4'd2; op_rd = 4'd3;
    @(posedge clk); #1;
    op_rs = 4'd3; op_rt = 4'd3; op_rd = 4'd5;
    check_eq("b2b_ready_read", 32'(op_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("b2b_ready_exec", 32'(op_ready), 32'd0);
    @(posedge clk); #1;
    check_eq("b2b_ready_wb", 32'(op_ready), 32'd0);
    check_eq("b2b1_c", 32'(rf_c), 32'h7);
    check_eq("b2b1_load", 32'(rf_load), 32'd1);
    mdl[3] = 16'h7;
    @(posedge clk); #1;
    check_eq("b2b_idle", 32'(op_ready), 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    check_eq("b2b2_acc", 32'(busy), 32'd1);
    check_eq("b2b2_aaddr", 32'(rf_aaddr), 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("b2b2_c", 32'(rf_c), 32'h000E);
    check_eq("b2b2_caddr", 32'(rf_caddr), 32'd5);
    check_eq("b2b2_load", 32'(rf_load), 32'd1);
    mdl[5] = 16'h000E;
    @(posedge clk); #1;
    check_eq("b2b2_mem", 32'(mem[5]), 32'h000E);

    // Asynchronous clear while the op is in EXEC.
    wait_ready();
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd0; op_rs = 4'd1; op_rt = 4'd2; op_rd = 4'd15;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    clear_n = 1'b0;
    #1;
    check_eq("clr_busy", 32'(busy), 32'd0);
    check_eq("clr_ready", 32'(op_ready), 32'd1);
    check_eq("clr_result", 32'(result), 32'd0);
    check_eq("clr_load", 32'(rf_load), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("clr_noload", 32'(rf_load), 32'd0);
    end
    @(negedge clk);
    clear_n = 1'b1;
    check_eq("clr_r15", 32'(mem[15]), 32'd0);
    run_op(3'd0, 4'd1, 4'd2, 4'd15, gc); check_eq("clr_next_c", 32'(gc), 32'h7);

    // Random operands and ops.
    for (int i = 1; i < 16; i++) preload(4'(i), 16'($urandom));
    for (int n = 0; n < 40; n++) begin
      rc = 3'($urandom_range(0, 7));
      run_op(rc, 4'($urandom), 4'($urandom), 4'($urandom), gc);
    end
    for (int i = 0; i < 16; i++) check_eq("final_mem", 32'(mem[i]), 32'(mdl[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
